lcd_init_sequencer: RTL and testbench

- Power-on initialisation sequencer for the 4-bit HD44780-style character LCD interface (data nibble, E, RS, RW).
- Sits directly downstream of the free-running clock counter generator. It consumes that counter's 26-bit count and drives the counter's enable to time each phase. Deasserting enable for one cycle zeroes the counter.
- Issues the standard 4-bit wake-up sequence (nibbles 0x3, 0x3, 0x3, 0x2) with the required delays, then flags init_done so the command/data writer can take over the bus.

---
 rtl/lcd_init_sequencer.sv | 177 +++++++++++++++++
 tb/tb_lcd_init_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_init_sequencer.sv
// Power-on wake-up sequencer for a 4-bit HD44780-style character LCD.
// It times every phase with an external free-running clock counter. The
// counter counts while cnt_enable is high and clears on the edge after
// cnt_enable drops. The sequencer issues nibbles 0x3, 0x3, 0x3, 0x2, each
// with its own gap, and then raises init_done.
module lcd_init_sequencer #(
    parameter int T_POWERUP = 750000,
    parameter int T_WAIT1   = 205000,
    parameter int T_WAIT2   = 5000,
    parameter int T_WAIT3   = 2000,
    parameter int T_SETUP   = 2,
    parameter int T_EPULSE  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] clk_cnt,
    input  logic        restart,
    output logic        cnt_enable,
    output logic [3:0]  lcd_data,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        init_done
);

    typedef enum logic [2:0] {
        ST_ARM     = 3'd0,
        ST_POWERUP = 3'd1,
        ST_SETUP   = 3'd2,
        ST_PULSE   = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Last count value of each timed state (duration N ends at count N-1).
    localparam logic [25:0] L_LAST_POWERUP = 26'(T_POWERUP - 1);
    localparam logic [25:0] L_LAST_WAIT1   = 26'(T_WAIT1 - 1);
    localparam logic [25:0] L_LAST_WAIT2   = 26'(T_WAIT2 - 1);
    localparam logic [25:0] L_LAST_WAIT3   = 26'(T_WAIT3 - 1);
    localparam logic [25:0] L_LAST_SETUP   = 26'(T_SETUP - 1);
    localparam logic [25:0] L_LAST_EPULSE  = 26'(T_EPULSE - 1);

    state_t      r_state;
    logic [1:0]  r_step;
    logic [3:0]  r_data;
    logic        r_e;
    logic        r_done;

    logic [25:0] w_last;
    logic        w_timed;
    logic        w_expired;

    // Nibble written for each step of the wake-up sequence.
    function automatic logic [3:0] step_nibble(input logic [1:0] step);
        logic [3:0] nib;
        case (step)
            2'd0:    nib = 4'h3;
            2'd1:    nib = 4'h3;
            2'd2:    nib = 4'h3;
            2'd3:    nib = 4'h2;
            default: nib = 4'h3;
        endcase
        return nib;
    endfunction

    // Final count of the gap that follows each step's E pulse.
    function automatic logic [25:0] gap_last(input logic [1:0] step);
        logic [25:0] last;
        case (step)
            2'd0:    last = L_LAST_WAIT1;
            2'd1:    last = L_LAST_WAIT2;
            2'd2:    last = L_LAST_WAIT3;
            2'd3:    last = L_LAST_WAIT3;
            default: last = L_LAST_WAIT3;
        endcase
        return last;
    endfunction

    // Select the final count of the current timed state; untimed states hold the counter clear.
    always_comb begin
        w_last  = 26'd0;
        w_timed = 1'b0;
        case (r_state)
            ST_POWERUP: begin
                w_last  = L_LAST_POWERUP;
                w_timed = 1'b1;
            end
            ST_SETUP: begin
                w_last  = L_LAST_SETUP;
                w_timed = 1'b1;
            end
            ST_PULSE: begin
                w_last  = L_LAST_EPULSE;
                w_timed = 1'b1;
            end
            ST_GAP: begin
                w_last  = gap_last(r_step);
                w_timed = 1'b1;
            end
            default: begin
                w_last  = 26'd0;
                w_timed = 1'b0;
            end
        endcase
    end

    // A count at or beyond the last value ends the phase, even when the count is stale or out of range.
    assign w_expired  = (clk_cnt >= w_last);
    assign cnt_enable = w_timed & ~w_expired;

    // Sequencer state machine with registered LCD strobe, data and done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ARM;
            r_step  <= 2'd0;
            r_data  <= 4'h0;
            r_e     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_ARM: begin
                    r_state <= ST_POWERUP;
                end
                ST_POWERUP: begin
                    if (w_expired) begin
                        r_state <= ST_SETUP;
                        r_data  <= step_nibble(r_step);
                    end
                end
                ST_SETUP: begin
                    if (w_expired) begin
                        r_state <= ST_PULSE;
                        r_e     <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (w_expired) begin
                        r_state <= ST_GAP;
                        r_e     <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (w_expired) begin
                        if (r_step == 2'd3) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_SETUP;
                            r_step  <= r_step + 2'd1;
                            r_data  <= step_nibble(r_step + 2'd1);
                        end
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        r_state <= ST_ARM;
                        r_step  <= 2'd0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_ARM;
                    r_step  <= 2'd0;
                    r_e     <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign lcd_data  = r_data;
    assign lcd_e     = r_e;
    assign init_done = r_done;
    assign lcd_rs    = 1'b0;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Self-checking bench for lcd_init_sequencer with small timing parameters.
// The bench contains its own model of the clock counter generator. A timeline
// model indexes the sequence by the number of edges since the sequence started.
// That model predicts every output on every cycle. Directed literal checks pin
// the timeline to hand-computed edge numbers.
module tb_lcd_init_sequencer;

    localparam int P_PWR   = 20;
    localparam int P_W1    = 10;
    localparam int P_W2    = 6;
    localparam int P_W3    = 4;
    localparam int P_SETUP = 2;
    localparam int P_EP    = 3;

    localparam int K_ARM   = 0;
    localparam int K_PWR   = 1;
    localparam int K_SETUP = 2;
    localparam int K_PULSE = 3;
    localparam int K_GAP   = 4;
    localparam int K_DONE  = 5;

    typedef struct {
        int kind;
        int off;
        int len;
        int step;
    } ph_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic        force_en = 1'b0;
    logic [25:0] cnt_q;
    logic [25:0] clk_cnt;
    logic        cnt_enable;
    logic [3:0]  lcd_data;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        init_done;

    int n_checks = 0;
    int n_errors = 0;
    int m_t;
    logic [3:0] m_carry;

    lcd_init_sequencer #(
        .T_POWERUP(P_PWR), .T_WAIT1(P_W1), .T_WAIT2(P_W2),
        .T_WAIT3(P_W3), .T_SETUP(P_SETUP), .T_EPULSE(P_EP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_cnt    (clk_cnt),
        .restart    (restart),
        .cnt_enable (cnt_enable),
        .lcd_data   (lcd_data),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // Clock counter generator: counts while enabled, clears on the edge after enable drops.
    always @(posedge clk or negedge reset) begin
        if (!reset)          cnt_q <= 26'd0;
        else if (!cnt_enable) cnt_q <= 26'd0;
        else                 cnt_q <= cnt_q + 26'd1;
    end

    assign clk_cnt = force_en ? 26'd50000000 : cnt_q;

    function automatic int gap_of(input int s);
        if (s == 0)      return P_W1;
        else if (s == 1) return P_W2;
        else             return P_W3;
    endfunction

    // Map cycle index t (edges since sequence start) to phase, offset and length.
    function automatic ph_t locate(input int t);
        ph_t p;
        int  base;
        p.kind = K_DONE; p.off = 0; p.len = 0; p.step = 3;
        if (t == 0) begin
            p.kind = K_ARM; p.len = 1;
            return p;
        end
        base = 1;
        if (t < base + P_PWR) begin
            p.kind = K_PWR; p.off = t - base; p.len = P_PWR;
            return p;
        end
        base += P_PWR;
        for (int s = 0; s < 4; s++) begin
            p.step = s;
            if (t < base + P_SETUP) begin
                p.kind = K_SETUP; p.off = t - base; p.len = P_SETUP;
                return p;
            end
            base += P_SETUP;
            if (t < base + P_EP) begin
                p.kind = K_PULSE; p.off = t - base; p.len = P_EP;
                return p;
            end
            base += P_EP;
            if (t < base + gap_of(s)) begin
                p.kind = K_GAP; p.off = t - base; p.len = gap_of(s);
                return p;
            end
            base += gap_of(s);
        end
        p.off = t - base;
        return p;
    endfunction

    function automatic int kind_at(input int t);
        ph_t p;
        p = locate(t);
        return p.kind;
    endfunction

    function automatic int next_start(input int t);
        ph_t p;
        p = locate(t);
        return t - p.off + p.len;
    endfunction

    function automatic bit is_timed(input int k);
        return (k == K_PWR) || (k == K_SETUP) || (k == K_PULSE) || (k == K_GAP);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d time=%0t)", name, got, exp, m_t, $time);
        end
    endtask

    // Model timeline: advance one step per edge. A restart in DONE or a forced expiry causes a jump.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_t     <= 0;
            m_carry <= 4'h0;
        end else if (kind_at(m_t) == K_DONE && restart) begin
            m_t     <= 0;
            m_carry <= 4'h2;
        end else if (force_en && is_timed(kind_at(m_t))) begin
            m_t     <= next_start(m_t);
        end else begin
            m_t     <= m_t + 1;
        end
    end

    // Compare every DUT output against the timeline model on each falling edge.
    initial begin
        ph_t        p;
        logic [3:0] exp_d;
        forever begin
            @(negedge clk);
            if (!force_en) begin
                p = locate(m_t);
                if (p.kind == K_SETUP || p.kind == K_PULSE || p.kind == K_GAP) exp_d = (p.step == 3) ? 4'h2 : 4'h3;
                else if (p.kind == K_DONE) exp_d = 4'h2;
                else exp_d = m_carry;
                check("lcd_rs", {31'd0, lcd_rs}, 32'd0);
                check("lcd_rw", {31'd0, lcd_rw}, 32'd0);
                check("lcd_e", {31'd0, lcd_e}, {31'd0, p.kind == K_PULSE});
                check("init_done", {31'd0, init_done}, {31'd0, p.kind == K_DONE});
                check("lcd_data", {28'd0, lcd_data}, {28'd0, exp_d});
                check("cnt_enable", {31'd0, cnt_enable}, {31'd0, is_timed(p.kind) && (p.off < p.len - 1)});
                if (is_timed(p.kind)) check("clk_cnt_in_state", {6'd0, clk_cnt}, p.off);
            end
        end
    end

    initial begin
        int rise_e[$];
        int fall_e[$];
        int rise_d[$];
        int exp_rise[4] = '{23, 38, 49, 58};
        int exp_fall[4] = '{26, 41, 52, 61};
        int exp_dat[4]  = '{3, 3, 3, 2};
        int done_edge;
        int drops;
        int k;
        logic prev_e;

        // Reset values while reset is held
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("rst_lcd_data", {28'd0, lcd_data}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
        #1 reset = 1'b1;

        // Run 1: record E edges and data; restart pulse during GAP of step 1 must be ignored
        done_edge = -1; drops = 0; prev_e = 1'b0;
        for (int e = 1; e <= 90; e++) begin
            @(posedge clk); #1;
            if (e == 43) restart = 1'b1;
            if (e == 44) restart = 1'b0;
            if (lcd_e && !prev_e) begin rise_e.push_back(e); rise_d.push_back(int'(lcd_data)); end
            if (!lcd_e && prev_e) fall_e.push_back(e);
            prev_e = lcd_e;
            if (init_done && done_edge < 0) done_edge = e;
            if (!init_done && done_edge >= 0) drops++;
        end
        check("done_edge", done_edge, 65);
        check("done_stays_high", drops, 0);
        check("e_rise_count", rise_e.size(), 4);
        check("e_fall_count", fall_e.size(), 4);
        if (rise_e.size() == 4 && fall_e.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("e_rise_edge", rise_e[i], exp_rise[i]);
                check("e_fall_edge", fall_e[i], exp_fall[i]);
                check("e_width", fall_e[i] - rise_e[i], P_EP);
                check("e_data", rise_d[i], exp_dat[i]);
            end
        end

        // Restart in DONE: init_done falls on the restart edge; sequence repeats in 65 edges
        @(negedge clk); restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        check("restart_done_low", {31'd0, init_done}, 32'd0);
        k = 0;
        while (!init_done && k < 200) begin
            @(posedge clk); #1; k++;
        end
        check("restart_done_edge", k, 65);

        // Reset during PULSE of step 2
        @(negedge clk); restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        repeat (48) @(posedge clk);
        @(posedge clk); #2;
        check("pre_reset_lcd_e", {31'd0, lcd_e}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("async_lcd_data", {28'd0, lcd_data}, 32'd0);
        check("async_init_done", {31'd0, init_done}, 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        k = 0;
        while (!lcd_e && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("first_e_after_reset", k, 23);

        // Out-of-range count during POWERUP ends the phase at once
        @(negedge clk); #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1 force_en = 1'b1;
        #1 check("forced_cnt_enable", {31'd0, cnt_enable}, 32'd0);
        @(posedge clk); #1 force_en = 1'b0;
        k = 0;
        while (!lcd_e && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("forced_e_edges", k, 2);
        k = 0;
        while (!init_done && k < 200) begin
            @(posedge clk); #1; k++;
        end
        check("forced_reaches_done", {31'd0, init_done}, 32'd1);

        // Randomized restarts and asynchronous resets, checked by the timeline model
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk); #1;
            restart = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 999) < 3) begin
                #($urandom_range(1, 3)) reset = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 reset = 1'b1;
            end
        end
        restart = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
